wb_stage: RTL
=============

Name: wb_stage

Overview:
- MEM/WB pipeline register and write-back select for the pipelined CPU.
- Captures MEM-stage results and forms the register-file write port: Rw, busW, WrEn, Jal.
- Provides a same-cycle forwarding tap for the hazard/forwarding logic.
- Maintains a retired-instruction counter.

Parameters:
- DW, 32, datapath width.
- AW, 5, register address width.
- CNTW, 32, retire counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- stall  in  1  hold the WB register contents.
- flush  in  1  load a bubble into WB.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_RegWr  in  1  instruction writes a register.
- mem_MemtoReg  in  1  result comes from data memory.
- mem_Jal  in  1  jal/jalr link write.
- mem_Rw  in  AW  destination register.
- mem_alu  in  DW  ALU result; bits [1:0] are the load byte offset.
- mem_dout  in  DW  data-memory read word.
- mem_pc  in  DW  instruction PC.
- mem_ldsz  in  2  load size: 00 word, 01 half, 10 byte.
- mem_ldu  in  1  unsigned load.
- Rw  out  AW  register-file write address.
- busW  out  DW  register-file write data.
- WrEn  out  1  register-file write enable.
- Jal  out  1  force write to r31.
- fwd_valid  out  1  forwarding tap valid (equals WrEn).
- fwd_Rw  out  AW  forwarding address (equals Rw).
- fwd_data  out  DW  forwarding data (equals busW).
- retired  out  CNTW  count of valid instructions retired.

Behaviour:
- Asynchronous reset (rst_n=0):
  - All WB fields clear; wb_valid=0.
  - Outputs Rw=0, busW=0, WrEn=0, Jal=0, fwd_valid=0, fwd_Rw=0, fwd_data=0, retired=0.
- WB register update, on posedge clk, in priority order:
  - flush=1: wb_valid<=0; all other fields <=0. Flush wins over stall.
  - Else stall=1: all fields hold.
  - Else: capture every mem_* input; wb_valid<=mem_valid.
- Latency: an instruction present in MEM at edge N drives the write port during cycle N..N+1. The register file commits it at edge N+1.
- Outputs are combinational from the WB register only. There is no combinational path from mem_* inputs to any output.
- Write-data select, priority order:
  - wb_Jal: busW = wb_pc + 8 (delay-slot link), modulo 2^DW.
  - wb_MemtoReg: busW = load-extracted wb_dout.
  - Otherwise: busW = wb_alu.
- Address and control:
  - Rw = 31 when wb_Jal, else wb_Rw.
  - Jal = wb_valid & wb_Jal.
  - WrEn = wb_valid & (wb_RegWr | wb_Jal) & (Rw != 0). A write to r0 is never issued.
- When wb_valid=0: Rw=0, busW=0, WrEn=0, Jal=0.
- Stall handling: while stalled, WrEn stays asserted for the held instruction. The same value is rewritten each cycle, which is idempotent and therefore allowed.
- Retire counter:
  - Increments by 1 at posedge clk when wb_valid=1 and stall=0 (the instruction leaves WB).
  - Wraps from 2^CNTW-1 to 0.
  - Counts every valid instruction, including those that do not write.
  - flush does not inhibit the count of the instruction leaving WB on that edge.
- Reset asserted mid-stall: takes effect immediately; any pending write is discarded.

Optional Feature:
- Macro: WB_LOAD_EXT_EN.
- Defined (load extraction selected by mem_ldsz, offset off = wb_alu[1:0], little-endian):
  - Byte: lane = wb_dout[8*off +: 8].
  - Half: lane = wb_dout[16*off[1] +: 16].
  - Word: full wb_dout.
  - Sign-extend the lane unless wb_ldu=1, in which case zero-extend.
- Undefined: mem_ldsz, mem_ldu and wb_alu[1:0] are ignored; a load writes wb_dout unmodified. The ports remain present.

Test Plan:
- Reset, then an ALU op (RegWr=1, Rw=5, alu=0x0000_1234, valid=1) -> next cycle Rw=5, busW=0x1234, WrEn=1, retired=1 after the following edge.
- jal with pc=0x0040_0010 and Rw=0 -> Rw=31, Jal=1, WrEn=1, busW=0x0040_0018.
- RegWr=1, Rw=0, alu=0xFFFF_FFFF -> WrEn=0; retired still increments.
- stall=1 for 3 cycles while a write is held -> WrEn, Rw and busW stable, retired unchanged. Then flush=1 together with stall=1 -> next cycle WrEn=0, busW=0.
- With WB_LOAD_EXT_EN defined: dout=0x80FF_7F01, ldsz=10, alu[1:0]=3, ldu=0 -> busW=0xFFFF_FF80. Same with ldu=1 -> 0x0000_0080. ldsz=01, alu[1]=1, ldu=0 -> 0xFFFF_80FF. Without the macro -> busW=0x80FF_7F01.
- Pulse rst_n low asynchronously mid-write -> all outputs 0 immediately, retired=0.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, write-back select, forwarding tap, retire count.
// Optional sub-word load extraction is enabled by defining WB_LOAD_EXT_EN.
module wb_stage #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic            mem_RegWr,
  input  logic            mem_MemtoReg,
  input  logic            mem_Jal,
  input  logic [AW-1:0]   mem_Rw,
  input  logic [DW-1:0]   mem_alu,
  input  logic [DW-1:0]   mem_dout,
  input  logic [DW-1:0]   mem_pc,
  input  logic [1:0]      mem_ldsz,
  input  logic            mem_ldu,
  output logic [AW-1:0]   Rw,
  output logic [DW-1:0]   busW,
  output logic            WrEn,
  output logic            Jal,
  output logic            fwd_valid,
  output logic [AW-1:0]   fwd_Rw,
  output logic [DW-1:0]   fwd_data,
  output logic [CNTW-1:0] retired
);

  typedef struct packed {
    logic          valid;
    logic          regwr;
    logic          memtoreg;
    logic          jal;
    logic [AW-1:0] rw;
    logic [DW-1:0] alu;
    logic [DW-1:0] dout;
    logic [DW-1:0] pc;
    logic [1:0]    ldsz;
    logic          ldu;
  } mem_wb_t;

  mem_wb_t         wb;
  mem_wb_t         nxt;
  logic [CNTW-1:0] cnt;

  always_comb begin
    nxt          = '0;
    nxt.valid    = mem_valid;
    nxt.regwr    = mem_RegWr;
    nxt.memtoreg = mem_MemtoReg;
    nxt.jal      = mem_Jal;
    nxt.rw       = mem_Rw;
    nxt.alu      = mem_alu;
    nxt.dout     = mem_dout;
    nxt.pc       = mem_pc;
    nxt.ldsz     = mem_ldsz;
    nxt.ldu      = mem_ldu;
  end

  // An instruction retires when it leaves WB, even if a flush
  // replaces it with a bubble on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb  <= '0;
      cnt <= '0;
    end else begin
      if (flush)
        wb <= '0;
      else if (!stall)
        wb <= nxt;
      if (wb.valid && !stall)
        cnt <= cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  logic [DW-1:0] ld;

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  lb;
  logic [15:0] lh;

  always_comb begin
    lb = '0;
    unique case (wb.alu[1:0])
      2'd0: lb = wb.dout[7:0];
      2'd1: lb = wb.dout[15:8];
      2'd2: lb = wb.dout[23:16];
      2'd3: lb = wb.dout[31:24];
    endcase
    lh = wb.alu[1] ? wb.dout[31:16] : wb.dout[15:0];
    unique case (1'b1)
      wb.ldsz == 2'b10:
        ld = {{(DW-8){~wb.ldu & lb[7]}}, lb};
      wb.ldsz == 2'b01:
        ld = {{(DW-16){~wb.ldu & lh[15]}}, lh};
      default:
        ld = wb.dout;
    endcase
  end
`else
  logic unused_ldext;

  assign ld           = wb.dout;
  assign unused_ldext = ^{wb.ldsz, wb.ldu, wb.alu[1:0]};
`endif

  logic [AW-1:0] rw_e;
  logic [DW-1:0] wd;

  always_comb begin
    rw_e = wb.jal ? AW'(31) : wb.rw;
    if (wb.jal)
      wd = wb.pc + DW'(8);
    else if (wb.memtoreg)
      wd = ld;
    else
      wd = wb.alu;
  end

  assign Rw        = wb.valid ? rw_e : '0;
  assign busW      = wb.valid ? wd : '0;
  assign Jal       = wb.valid & wb.jal;
  assign WrEn      = wb.valid & (wb.regwr | wb.jal)
                   & (rw_e != '0);
  assign fwd_valid = WrEn;
  assign fwd_Rw    = Rw;
  assign fwd_data  = busW;
  assign retired   = cnt;

endmodule
